chip8_loader: RTL and testbench
===============================

# chip8_loader

Program loader for the CHIP-8 core: the writer side of the chip8 memory that the CPU only reads. It accepts a program as a valid/ready byte stream and writes it into memory starting at 0x200, optionally preloading the hex font first. It holds the CPU in reset until the image is complete.

## Interface

Parameters:
- LOAD_BASE, 12'h200: address of the first program byte.
- FONT_BASE, 12'h050: address of the first font byte (used only when the font is compiled in).

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the byte on in_data is offered.
- in_data  input  8  program byte.
- in_last  input  1  marks the final program byte; qualified by in_valid.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  memory write strobe, one cycle per byte.
- mem_waddr  output  12  memory write address.
- mem_wdata  output  8  memory write data.
- cpu_hold  output  1  keeps the CPU in reset while high.
- done  output  1  image loaded; stays high.
- error  output  1  image overflowed the address space; stays high.
- byte_count  output  13  number of program bytes accepted (font bytes excluded).
- checksum  output  8  mod-256 sum of accepted program bytes.

## Operation

- States: FONT, RECV, DRAIN, DONE, ERROR.
- Leaving reset, the loader enters FONT if CHIP8_LOADER_FONT_EN is defined, otherwise RECV.
- FONT:
  - Writes 80 bytes from an internal ROM to FONT_BASE..FONT_BASE+79, one byte per cycle.
  - in_ready=0 throughout.
  - After the 80th write it goes to RECV.
- RECV:
  - in_ready=1. A byte is accepted on any cycle where in_valid && in_ready.
  - Each accepted byte is written at addr_ptr. addr_ptr starts at LOAD_BASE and increments by 1 per byte, in 12 bits.
  - byte_count increments by 1 per accepted byte; checksum adds in_data, wrapping mod 256.
  - Accepted byte with in_last=1: go to DRAIN.
  - Accepted byte with in_last=0 when addr_ptr==12'hFFF: the byte is still written, then go to ERROR. The pointer is not allowed to wrap to 0x000.
- DRAIN: one cycle in which the final write completes. in_ready=0. Then go to DONE.
- DONE: done=1, cpu_hold=0, in_ready=0. Held until reset; further input is ignored.
- ERROR: error=1, cpu_hold=1, in_ready=0. Held until reset.
- in_last on a cycle where nothing is accepted is ignored.
- The stream may stall at any point; bubbles have no effect on the write addresses.
- Reset mid-load:
  - Returns to the initial state; all counters return to 0.
  - Memory contents are not cleared; the next load overwrites them.
  - With the font enabled, the font is rewritten.

## Timing

- Values during reset and on the first cycle after it: mem_we=0, mem_waddr=0, mem_wdata=0, in_ready=0, cpu_hold=1, done=0, error=0, byte_count=0, checksum=0.
- in_ready is registered and depends only on state. In RECV it is first high on the cycle after the state is entered.
- Write latency: a byte accepted at edge N appears on mem_we/mem_waddr/mem_wdata during cycle N..N+1. Memory commits it at edge N+1.
- mem_we is low on every cycle without a write.
- Throughput: one byte per cycle, both in FONT and in RECV.
- Last byte accepted at edge N: DRAIN during N..N+1. DONE from edge N+1, so done rises and cpu_hold falls after the last write has committed.
- Overflow: the byte at 0xFFF accepted at edge N gives error=1 and in_ready=0 from edge N+1.
- byte_count and checksum update at the same edge as acceptance.

## Configuration

- Macro CHIP8_LOADER_FONT_EN.
- Defined:
  - FONT state and an 80-byte ROM holding the standard 0–F sprites, 5 bytes each.
  - Font occupies FONT_BASE..FONT_BASE+79.
  - The first in_ready comes 81 cycles after reset deasserts.
- Undefined:
  - No ROM and no FONT state.
  - RECV is entered directly; in_ready is high on the second cycle after reset.
  - The font region is never written.

## Test plan

- Font off; stream 4 bytes A2,1E,60,05 back-to-back with in_last on the 4th -> writes at 0x200–0x203 on consecutive cycles; byte_count=4; checksum=0x25; done=1 and cpu_hold=0 two cycles after the last acceptance.
- Font on; hold in_valid high from reset -> 80 writes to 0x050–0x09F, first byte F0, last byte 80; in_ready stays 0 until they finish, then the first program byte goes to 0x200.
- Random in_valid bubbles over a 100-byte image -> addresses contiguous from 0x200 to 0x263, no duplicate or missing writes, byte_count=100.
- Stream 3584 bytes (0x200–0xFFF) with no in_last -> last write at 0xFFF, then error=1, in_ready=0, cpu_hold=1, no write to 0x000.
- Reset pulsed after 10 bytes, then a 2-byte image -> writes restart at 0x200; byte_count=2; done=1.
- In DONE, drive in_valid=1 for 5 cycles -> no mem_we; byte_count and checksum unchanged.

Source files
------------

// File: rtl/chip8_loader.sv
// chip8_loader: streams a program image into CHIP-8 memory at LOAD_BASE, holding the CPU in reset until done.
// Optional hex-font preload at FONT_BASE is enabled by defining CHIP8_LOADER_FONT_EN.
`default_nettype none

module chip8_loader #(
    parameter logic [11:0] LOAD_BASE = 12'h200,
    parameter logic [11:0] FONT_BASE = 12'h050
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        mem_we,
    output logic [11:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [12:0] byte_count,
    output logic [7:0]  checksum
);

`ifdef CHIP8_LOADER_FONT_EN
    typedef enum logic [2:0] {
        S_FONT  = 3'd0,
        S_RECV  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;
    localparam state_t INIT_STATE = S_FONT;

    // Sprites 0..F, five rows each; byte 0 sits in the top bits.
    localparam logic [639:0] FONT_ROM = {
        40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
        40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
        40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
        40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
    };

    logic [6:0] font_idx;
`else
    typedef enum logic [2:0] {
        S_RECV  = 3'd1,
        S_DRAIN = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;
    localparam state_t INIT_STATE = S_RECV;
`endif

    state_t      state;
    logic [11:0] addr_ptr;
    logic        accept;

    // in_ready is only ever high in RECV, so accept implies RECV.
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT_STATE;
            addr_ptr   <= LOAD_BASE;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_waddr  <= 12'h000;
            mem_wdata  <= 8'h00;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            byte_count <= 13'd0;
            checksum   <= 8'h00;
`ifdef CHIP8_LOADER_FONT_EN
            font_idx   <= 7'd0;
`endif
        end else begin
            mem_we <= 1'b0;
            case (state)
`ifdef CHIP8_LOADER_FONT_EN
                S_FONT: begin
                    mem_we    <= 1'b1;
                    mem_waddr <= FONT_BASE + {5'd0, font_idx};
                    mem_wdata <= FONT_ROM[10'd639 - {font_idx, 3'b000} -: 8];
                    if (font_idx == 7'd79) begin
                        state <= S_RECV;
                    end else begin
                        font_idx <= font_idx + 7'd1;
                    end
                end
`endif
                S_RECV: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mem_we     <= 1'b1;
                        mem_waddr  <= addr_ptr;
                        mem_wdata  <= in_data;
                        byte_count <= byte_count + 13'd1;
                        checksum   <= checksum + in_data;
                        if (in_last) begin
                            state    <= S_DRAIN;
                            in_ready <= 1'b0;
                        end else if (addr_ptr == 12'hFFF) begin
                            // Top of memory reached without in_last: never wrap onto 0x000.
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                        end else begin
                            addr_ptr <= addr_ptr + 12'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    state    <= S_DONE;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                S_DONE: begin
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
                end
                S_ERROR: begin
                    error    <= 1'b1;
                    cpu_hold <= 1'b1;
                end
                default: begin
                    state <= S_ERROR;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_chip8_loader.sv
// tb_chip8_loader: directed scoreboard bench for chip8_loader (font on or off per CHIP8_LOADER_FONT_EN).
`timescale 1ns/1ps
`default_nettype none

module tb_chip8_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [12:0] byte_count;
    logic [7:0]  checksum;

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int nwrites = 0;
    int stalls = 0;

    logic [19:0] q[$];
    logic [11:0] exp_addr;
    logic [12:0] exp_count;
    logic [7:0]  exp_sum;

`ifdef CHIP8_LOADER_FONT_EN
    localparam int FONT_N = 80;
    localparam int READY_LAT = 81;
    logic [7:0] font_tab [0:79] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };
`else
    localparam int FONT_N = 0;
    localparam int READY_LAT = 1;
`endif

    localparam logic [63:0] RST_VEC = {18'b0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 13'd0, 8'h00};

    always #5 clk = ~clk;

    chip8_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .byte_count (byte_count),
        .checksum   (checksum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {18'b0, mem_we, mem_waddr, mem_wdata, in_ready, cpu_hold, done, error, byte_count, checksum};
    endfunction

    // Every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_we) begin
            nwrites++;
            check("write_was_expected", (q.size() > 0), 1);
            if (q.size() > 0) check("write_addr_data", {mem_waddr, mem_wdata}, q.pop_front());
        end
    end

    task automatic do_reset(input bit hold_valid);
        int n;
        reset = 1'b1;
        in_valid = hold_valid;
        in_data = 8'hA2;
        in_last = 1'b0;
        @(negedge clk);
        check("writes_drained", q.size(), 0);
        @(negedge clk);
        check("reset_outputs", outs(), RST_VEC);
        reset = 1'b0;
        exp_addr = 12'h200;
        exp_count = 13'd0;
        exp_sum = 8'h00;
        nwrites = 0;
        stalls = 0;
`ifdef CHIP8_LOADER_FONT_EN
        for (int i = 0; i < 80; i++) q.push_back({12'h050 + 12'(i), font_tab[i]});
`endif
        check("post_reset_outputs", outs(), RST_VEC);
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency", n, READY_LAT);
        check("font_done_before_ready", q.size(), 0);
        check("font_write_count", nwrites, FONT_N);
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        bit acc;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        do begin
            acc = in_ready;
            @(posedge clk);
            if (acc) begin
                q.push_back({exp_addr, d});
                exp_addr++;
                exp_count++;
                exp_sum += d;
            end else begin
                stalls++;
                n++;
            end
            @(negedge clk);
        end while (!acc && n < 100);
        if (!acc) check("accept_timeout", n, 0);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Back-to-back 4-byte image, in_valid held from reset.
        do_reset(1'b1);
        send(8'hA2, 1'b0);
        send(8'h1E, 1'b0);
        send(8'h60, 1'b0);
        send(8'h05, 1'b1);
        check("b2b_no_stalls", stalls, 0);
        check("drain_ready", in_ready, 0);
        check("drain_done", done, 0);
        check("drain_hold", cpu_hold, 1);
        in_valid = 1'b0;
        @(negedge clk);
        check("done_high", done, 1);
        check("hold_low", cpu_hold, 0);
        check("count4", byte_count, 13'd4);
        check("sum4", checksum, 8'h25);
        check("no_error", error, 0);

        // Input in DONE is ignored.
        in_valid = 1'b1;
        in_data = 8'hFF;
        in_last = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("done_count_kept", byte_count, 13'd4);
        check("done_sum_kept", checksum, 8'h25);
        check("done_ready_low", in_ready, 0);
        check("done_writes", nwrites, FONT_N + 4);

        // 100-byte image with random bubbles (in_last high during bubbles).
        do_reset(1'b0);
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) idle();
            send(8'($urandom), (i == 99));
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("rand_done", done, 1);
        check("rand_count", byte_count, exp_count);
        check("rand_count100", byte_count, 13'd100);
        check("rand_sum", checksum, exp_sum);
        check("rand_writes", nwrites, FONT_N + 100);

        // Reset after 10 bytes, then a 2-byte image.
        do_reset(1'b0);
        for (int i = 0; i < 10; i++) send(8'(i + 16), 1'b0);
        check("mid_count10", byte_count, 13'd10);
        do_reset(1'b0);
        send(8'h12, 1'b0);
        send(8'h34, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("restart_count", byte_count, 13'd2);
        check("restart_sum", checksum, 8'h46);
        check("restart_done", done, 1);

        // Fill 0x200..0xFFF without in_last.
        do_reset(1'b0);
        for (int i = 0; i < 3584; i++) send(8'(i) ^ 8'h5A, 1'b0);
        check("ovf_no_stalls", stalls, 0);
        check("ovf_ready_drop", in_ready, 0);
        @(negedge clk);
        check("ovf_error", error, 1);
        check("ovf_ready", in_ready, 0);
        check("ovf_hold", cpu_hold, 1);
        check("ovf_done", done, 0);
        check("ovf_count", byte_count, 13'd3584);
        check("ovf_sum", checksum, exp_sum);
        in_valid = 1'b1;
        in_last = 1'b0;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("ovf_writes", nwrites, FONT_N + 3584);
        check("ovf_error_sticky", error, 1);
        check("ovf_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
